// File: rtl/wdr_pkg.sv
// Shared types and constants for the watchdog fail responder.
package wdr_pkg;

    // Responder state machine
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRACE = 3'd1,
        RESET = 3'd2,
        HOLD  = 3'd3,
        LOCK  = 3'd4
    } wdr_state_e;

    // Fault codes reported by the detector on FLSTAT
    localparam logic [2:0] FL_NONE   = 3'b000;
    localparam logic [2:0] FL_FWOVR  = 3'b001;
    localparam logic [2:0] FL_EARLY  = 3'b010;
    localparam logic [2:0] FL_DOUBLE = 3'b011;
    localparam logic [2:0] FL_MISS   = 3'b100;

    // Firmware override skips the grace window; every other code (known or not) gets one.
    function automatic logic takes_grace(input logic [2:0] code);
        return code != FL_FWOVR;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic q1_q;
    logic q2_q;

    // Two back-to-back flops to settle a possibly metastable sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/wd_fail_responder.sv
// Watchdog fail responder: latches the fault, grants a grace window, issues a
// timed SYSRST pulse and locks out after repeated resets.
// Optional fault history log is built only when WDR_FLTLOG_EN is defined.
module wd_fail_responder
    import wdr_pkg::*;
#(
    parameter int GRACE_CYC = 16,
    parameter int RST_WIDTH = 8,
    parameter int MAX_FAIL  = 3,
    parameter int CNT_W     = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             WDFAIL,
    input  logic [2:0]       FLSTAT,
    input  logic             CLRFLT,
    output logic             SYSRST,
    output logic             ALARM,
    output logic [2:0]       FLTCODE,
    output logic [CNT_W-1:0] FLTCNT,
    output logic             LOCKOUT,
    output logic [11:0]      FLTHIST
);

    // One shared down-counter serves both the grace window and the reset pulse
    localparam int TMR_MAX = (GRACE_CYC > RST_WIDTH) ? GRACE_CYC : RST_WIDTH;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    wdr_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             sysrst_q, sysrst_d;
    logic             alarm_q, alarm_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic             wf_q3_q, wf_q3_d;
    logic             rise_q, rise_d;
    logic [2:0]       flstat_q, flstat_d;

    logic wf_s;
    logic wf_rise;
    logic fault_take;
    logic clr_take;

    sync_2ff u_sync (
        .clk  (CLK),
        .rst_n(RSTN),
        .d    (WDFAIL),
        .q    (wf_s)
    );

    assign wf_rise    = wf_s & ~wf_q3_q;
    // The FSM acts on the registered rise so it sees the code captured with it
    assign fault_take = (state_q == IDLE) && rise_q;
    // A clear coinciding with a detected rise (raw or registered) is dropped
    assign clr_take   = (state_q == IDLE) && !rise_q && !wf_rise && CLRFLT;

    // Next-state and output computation
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        sysrst_d = sysrst_q;
        alarm_d  = alarm_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        wf_q3_d  = wf_s;
        rise_d   = wf_rise;
        flstat_d = wf_rise ? FLSTAT : flstat_q;

        case (state_q)
            IDLE: begin
                if (fault_take) begin
                    code_d  = flstat_q;
                    alarm_d = 1'b1;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (takes_grace(flstat_q)) begin
                        state_d = GRACE;
                        tmr_d   = TMR_W'(GRACE_CYC - 1);
                    end else begin
                        state_d  = RESET;
                        tmr_d    = TMR_W'(RST_WIDTH - 1);
                        sysrst_d = 1'b1;
                    end
                end else if (clr_take) begin
                    alarm_d = 1'b0;
                    code_d  = FL_NONE;
                    cnt_d   = '0;
                end
            end
            GRACE: begin
                if (!wf_s) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    state_d  = RESET;
                    tmr_d    = TMR_W'(RST_WIDTH - 1);
                    sysrst_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RESET: begin
                if (tmr_q == '0) begin
                    if (cnt_q >= CNT_W'(MAX_FAIL)) begin
                        state_d = LOCK;
                        lock_d  = 1'b1;
                    end else begin
                        state_d  = HOLD;
                        sysrst_d = 1'b0;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            HOLD: begin
                if (!wf_s) state_d = IDLE;
            end
            LOCK: begin
                sysrst_d = 1'b1;
                lock_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer, edge-detect and output registers
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            sysrst_q <= 1'b0;
            alarm_q  <= 1'b0;
            code_q   <= FL_NONE;
            cnt_q    <= '0;
            lock_q   <= 1'b0;
            wf_q3_q  <= 1'b0;
            rise_q   <= 1'b0;
            flstat_q <= FL_NONE;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            sysrst_q <= sysrst_d;
            alarm_q  <= alarm_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            wf_q3_q  <= wf_q3_d;
            rise_q   <= rise_d;
            flstat_q <= flstat_d;
        end
    end

`ifdef WDR_FLTLOG_EN
    logic [11:0] hist_q, hist_d;

    // Shift each accepted fault code into the log; cleared with the fault state
    always_comb begin
        hist_d = hist_q;
        if (fault_take)    hist_d = {hist_q[8:0], flstat_q};
        else if (clr_take) hist_d = '0;
    end

    // Fault history register
    always_ff @(posedge CLK) begin
        if (!RSTN) hist_q <= '0;
        else       hist_q <= hist_d;
    end

    assign FLTHIST = hist_q;
`else
    assign FLTHIST = '0;
`endif

    assign SYSRST  = sysrst_q;
    assign ALARM   = alarm_q;
    assign FLTCODE = code_q;
    assign FLTCNT  = cnt_q;
    assign LOCKOUT = lock_q;

endmodule
